// File: rtl/loac_pkg.sv
// Shared constants and state encoding for the grade averaging unit.
// Imported by the averaging core and its interface.
package loac_pkg;

  localparam int NBITS_NOTA = 4;
  localparam int NOTA_MAX   = 10;

  typedef enum logic [1:0] {
    COLETA,
    DIVIDE,
    PRONTO
  } estado_media_t;

endpackage

// File: rtl/media_notas_if.sv
// Score entry / average result bundle between the switch panel
// and the averaging core.
interface media_notas_if #(
  parameter int NBITS_NOTA = loac_pkg::NBITS_NOTA,
  parameter int NPROVAS    = 4
) ();

  localparam int CW = $clog2(NPROVAS) + 1;

  logic [NBITS_NOTA-1:0] entrada;
  logic                  confirma;
  logic                  limpa;
  logic [NBITS_NOTA-1:0] nota;
  logic                  nota_valida;
  logic [CW-1:0]         contagem;
  logic                  ocupado;
  logic                  erro;

  modport master (
    output entrada,
    output confirma,
    output limpa,
    input  nota,
    input  nota_valida,
    input  contagem,
    input  ocupado,
    input  erro
  );

  modport slave (
    input  entrada,
    input  confirma,
    input  limpa,
    output nota,
    output nota_valida,
    output contagem,
    output ocupado,
    output erro
  );

endinterface

// File: rtl/detector_borda.sv
// One-bit rising-edge detector; a held level yields a single
// one-cycle pulse.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic borda
);

  logic ant_q;
  logic ant_d;

  // previous level follows the input every cycle
  always_comb begin
    ant_d = d;
  end

  // previous-level register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ant_q <= 1'b0;
    end else begin
      ant_q <= ant_d;
    end
  end

  assign borda = d & ~ant_q;

endmodule

// File: rtl/media_notas.sv
// Collects NPROVAS scores and produces their floor average by
// repeated subtraction, one subtraction per clock.
module media_notas #(
  parameter int NBITS_NOTA = loac_pkg::NBITS_NOTA,
  parameter int NOTA_MAX   = loac_pkg::NOTA_MAX,
  parameter int NPROVAS    = 4,
  parameter int NBITS_SOMA = NBITS_NOTA + $clog2(NPROVAS)
) (
  input  logic         clk_2,
  input  logic         rst_n,
  media_notas_if.slave bus
);

  import loac_pkg::*;

  localparam int CW = $clog2(NPROVAS) + 1;

  localparam logic [NBITS_NOTA-1:0] MAX_V =
    NBITS_NOTA'(NOTA_MAX);
  localparam logic [CW-1:0] ULTIMA =
    CW'(NPROVAS - 1);
  localparam logic [NBITS_SOMA-1:0] DIVISOR =
    NBITS_SOMA'(NPROVAS);

  estado_media_t estado_q, estado_d;

  logic [NBITS_SOMA-1:0] soma_q, soma_d;
  logic [NBITS_SOMA-1:0] resto_q, resto_d;
  logic [NBITS_NOTA-1:0] quoc_q, quoc_d;
  logic [NBITS_NOTA-1:0] nota_q, nota_d;
  logic [CW-1:0]         contagem_q, contagem_d;
  logic                  valida_q, valida_d;
  logic                  ocupado_q, ocupado_d;
  logic                  erro_q, erro_d;

  logic                  aceita;
  logic                  legal;
  logic                  ultima;
  logic                  resto_ge;
  logic [NBITS_SOMA-1:0] entrada_ext;
  logic [NBITS_SOMA-1:0] soma_mais;

  detector_borda u_borda (
    .clk   (clk_2),
    .rst_n (rst_n),
    .d     (bus.confirma),
    .borda (aceita)
  );

  assign legal       = (bus.entrada <= MAX_V);
  assign ultima      = (contagem_q == ULTIMA);
  assign resto_ge    = (resto_q >= DIVISOR);
  assign entrada_ext = NBITS_SOMA'(bus.entrada);
  assign soma_mais   = soma_q + entrada_ext;

  // state and datapath registers
  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      estado_q   <= COLETA;
      soma_q     <= '0;
      resto_q    <= '0;
      quoc_q     <= '0;
      nota_q     <= '0;
      contagem_q <= '0;
      valida_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      soma_q     <= soma_d;
      resto_q    <= resto_d;
      quoc_q     <= quoc_d;
      nota_q     <= nota_d;
      contagem_q <= contagem_d;
      valida_q   <= valida_d;
      ocupado_q  <= ocupado_d;
      erro_q     <= erro_d;
    end
  end

  // next state: clear wins over any submission
  always_comb begin
    estado_d = estado_q;
    if (bus.limpa) begin
      estado_d = COLETA;
    end else begin
      unique case (estado_q)
        COLETA: begin
          if (aceita && legal && ultima) begin
            estado_d = DIVIDE;
          end
        end
        DIVIDE: begin
          if (!resto_ge) begin
            estado_d = PRONTO;
          end
        end
        PRONTO: begin
          if (aceita && legal) begin
            estado_d = COLETA;
          end
        end
        default: estado_d = COLETA;
      endcase
    end
  end

  // accumulation, division steps and result hand-off
  always_comb begin
    soma_d     = soma_q;
    resto_d    = resto_q;
    quoc_d     = quoc_q;
    nota_d     = nota_q;
    contagem_d = contagem_q;
    valida_d   = valida_q;
    ocupado_d  = ocupado_q;
    erro_d     = erro_q;
    if (bus.limpa) begin
      soma_d     = '0;
      contagem_d = '0;
      erro_d     = 1'b0;
      valida_d   = 1'b0;
      ocupado_d  = 1'b0;
    end else begin
      unique case (estado_q)
        COLETA: begin
          if (aceita) begin
            if (!legal) begin
              erro_d = 1'b1;
            end else begin
              soma_d     = soma_mais;
              contagem_d = contagem_q + CW'(1);
              erro_d     = 1'b0;
              if (ultima) begin
                resto_d   = soma_mais;
                quoc_d    = '0;
                ocupado_d = 1'b1;
              end
            end
          end
        end
        DIVIDE: begin
          if (resto_ge) begin
            resto_d = resto_q - DIVISOR;
            quoc_d  = quoc_q + NBITS_NOTA'(1);
          end else begin
            nota_d     = quoc_q;
            valida_d   = 1'b1;
            ocupado_d  = 1'b0;
            soma_d     = '0;
            contagem_d = '0;
          end
        end
        PRONTO: begin
          if (aceita) begin
            if (legal) begin
              valida_d   = 1'b0;
              soma_d     = entrada_ext;
              contagem_d = CW'(1);
              erro_d     = 1'b0;
            end else begin
              erro_d = 1'b1;
            end
          end
        end
        default: begin
          soma_d = soma_q;
        end
      endcase
    end
  end

  assign bus.nota        = nota_q;
  assign bus.nota_valida = valida_q;
  assign bus.contagem    = contagem_q;
  assign bus.ocupado     = ocupado_q;
  assign bus.erro        = erro_q;

endmodule

// File: tb/tb_media_notas.sv
// Directed bench for the grade averaging unit.
// Outputs are sampled on the falling edge of clk_2.
module tb_media_notas;

  logic clk_2;
  logic rst_n;

  int nvec;
  int nerr;

  media_notas_if #(.NBITS_NOTA(4), .NPROVAS(4)) bus ();

  media_notas #(.NPROVAS(4)) dut (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic press(input logic [3:0] v);
    @(negedge clk_2);
    bus.entrada  = v;
    bus.confirma = 1'b1;
    @(negedge clk_2);
    bus.confirma = 1'b0;
  endtask

  task automatic press_timed(
    input  logic [3:0] v,
    output int         n,
    output int         busy,
    output logic [2:0] cont1
  );
    n     = 0;
    busy  = 0;
    cont1 = '0;
    @(negedge clk_2);
    bus.entrada  = v;
    bus.confirma = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_2);
      bus.confirma = 1'b0;
      n++;
      if (n == 1) cont1 = bus.contagem;
      if (bus.ocupado) busy++;
      if (bus.nota_valida) break;
    end
  endtask

  task automatic do_limpa;
    @(negedge clk_2);
    bus.limpa = 1'b1;
    @(negedge clk_2);
    bus.limpa = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_2);
    nvec++;
    if (bus.nota !== 4'd0) begin
      $display("FAIL reset_nota got %0d want 0", bus.nota);
      nerr++;
    end
    nvec++;
    if (bus.nota_valida !== 1'b0 || bus.ocupado !== 1'b0 ||
        bus.erro !== 1'b0 || bus.contagem !== 3'd0) begin
      $display("FAIL reset_flags got v=%b o=%b e=%b c=%0d want 0",
               bus.nota_valida, bus.ocupado, bus.erro, bus.contagem);
      nerr++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_media_7;
    int n, busy;
    logic [2:0] c1;
    press(4'd7);
    press(4'd8);
    press(4'd9);
    nvec++;
    if (bus.contagem !== 3'd3) begin
      $display("FAIL m7_count3 got %0d want 3", bus.contagem);
      nerr++;
    end
    press_timed(4'd6, n, busy, c1);
    nvec++;
    if (c1 !== 3'd4) begin
      $display("FAIL m7_count4 got %0d want 4", c1);
      nerr++;
    end
    nvec++;
    if (busy !== 8) begin
      $display("FAIL m7_busy got %0d want 8", busy);
      nerr++;
    end
    nvec++;
    if (n !== 9) begin
      $display("FAIL m7_latency got %0d want 9", n);
      nerr++;
    end
    nvec++;
    if (bus.nota !== 4'd7 || bus.nota_valida !== 1'b1) begin
      $display("FAIL m7_nota got %0d/%b want 7/1",
               bus.nota, bus.nota_valida);
      nerr++;
    end
    nvec++;
    if (bus.contagem !== 3'd0 || bus.ocupado !== 1'b0) begin
      $display("FAIL m7_done got c=%0d o=%b want 0/0",
               bus.contagem, bus.ocupado);
      nerr++;
    end
  endtask

  task automatic test_pronto_nova;
    int n, busy;
    logic [2:0] c1;
    press(4'd5);
    press(4'd4);
    press(4'd3);
    press_timed(4'd4, n, busy, c1);
    nvec++;
    if (n !== 6 || bus.nota !== 4'd4 || bus.nota_valida !== 1'b1) begin
      $display("FAIL pn_nota got n=%0d nota=%0d v=%b want 6/4/1",
               n, bus.nota, bus.nota_valida);
      nerr++;
    end
    press(4'd2);
    nvec++;
    if (bus.nota_valida !== 1'b0 || bus.contagem !== 3'd1) begin
      $display("FAIL pn_restart got v=%b c=%0d want 0/1",
               bus.nota_valida, bus.contagem);
      nerr++;
    end
    nvec++;
    if (bus.nota !== 4'd4) begin
      $display("FAIL pn_keep got %0d want 4", bus.nota);
      nerr++;
    end
  endtask

  task automatic test_bordas;
    int n, busy;
    logic [2:0] c1;
    do_limpa();
    press(4'd0);
    press(4'd0);
    press(4'd0);
    press_timed(4'd0, n, busy, c1);
    nvec++;
    if (n !== 2 || bus.nota !== 4'd0 || bus.nota_valida !== 1'b1) begin
      $display("FAIL zeros got n=%0d nota=%0d v=%b want 2/0/1",
               n, bus.nota, bus.nota_valida);
      nerr++;
    end
    press(4'd10);
    press(4'd10);
    press(4'd10);
    press_timed(4'd10, n, busy, c1);
    nvec++;
    if (n !== 12 || bus.nota !== 4'd10 || bus.nota_valida !== 1'b1) begin
      $display("FAIL tens got n=%0d nota=%0d v=%b want 12/10/1",
               n, bus.nota, bus.nota_valida);
      nerr++;
    end
    press(4'd15);
    nvec++;
    if (bus.erro !== 1'b1 || bus.nota_valida !== 1'b1 ||
        bus.nota !== 4'd10) begin
      $display("FAIL pronto_bad got e=%b v=%b nota=%0d want 1/1/10",
               bus.erro, bus.nota_valida, bus.nota);
      nerr++;
    end
  endtask

  task automatic test_erro;
    do_limpa();
    press(4'd3);
    press(4'd12);
    nvec++;
    if (bus.erro !== 1'b1 || bus.contagem !== 3'd1) begin
      $display("FAIL err_set got e=%b c=%0d want 1/1",
               bus.erro, bus.contagem);
      nerr++;
    end
    press(4'd6);
    nvec++;
    if (bus.erro !== 1'b0 || bus.contagem !== 3'd2) begin
      $display("FAIL err_clr got e=%b c=%0d want 0/2",
               bus.erro, bus.contagem);
      nerr++;
    end
  endtask

  task automatic test_held;
    do_limpa();
    @(negedge clk_2);
    bus.entrada  = 4'd5;
    bus.confirma = 1'b1;
    repeat (20) @(negedge clk_2);
    bus.confirma = 1'b0;
    @(negedge clk_2);
    nvec++;
    if (bus.contagem !== 3'd1) begin
      $display("FAIL held got %0d want 1", bus.contagem);
      nerr++;
    end
  endtask

  task automatic test_limpa_divide;
    do_limpa();
    press(4'd7);
    press(4'd8);
    press(4'd9);
    @(negedge clk_2);
    bus.entrada  = 4'd6;
    bus.confirma = 1'b1;
    @(negedge clk_2);
    bus.confirma = 1'b0;
    nvec++;
    if (bus.ocupado !== 1'b1) begin
      $display("FAIL ld_busy got %b want 1", bus.ocupado);
      nerr++;
    end
    bus.limpa = 1'b1;
    @(negedge clk_2);
    bus.limpa = 1'b0;
    nvec++;
    if (bus.ocupado !== 1'b0 || bus.contagem !== 3'd0 ||
        bus.nota_valida !== 1'b0 || bus.nota !== 4'd10) begin
      $display("FAIL ld_clear got o=%b c=%0d v=%b n=%0d want 0/0/0/10",
               bus.ocupado, bus.contagem, bus.nota_valida, bus.nota);
      nerr++;
    end
    repeat (12) @(negedge clk_2);
    nvec++;
    if (bus.nota_valida !== 1'b0 || bus.nota !== 4'd10) begin
      $display("FAIL ld_abandon got v=%b n=%0d want 0/10",
               bus.nota_valida, bus.nota);
      nerr++;
    end
  endtask

  task automatic test_reset_mid;
    press(4'd3);
    press(4'd12);
    nvec++;
    if (bus.erro !== 1'b1 || bus.contagem !== 3'd1) begin
      $display("FAIL rm_pre got e=%b c=%0d want 1/1",
               bus.erro, bus.contagem);
      nerr++;
    end
    rst_n = 1'b0;
    @(negedge clk_2);
    rst_n = 1'b1;
    nvec++;
    if (bus.nota !== 4'd0 || bus.nota_valida !== 1'b0 ||
        bus.contagem !== 3'd0 || bus.ocupado !== 1'b0 ||
        bus.erro !== 1'b0) begin
      $display("FAIL rm_zero got n=%0d v=%b c=%0d o=%b e=%b want 0",
               bus.nota, bus.nota_valida, bus.contagem,
               bus.ocupado, bus.erro);
      nerr++;
    end
    press(4'd8);
    nvec++;
    if (bus.contagem !== 3'd1) begin
      $display("FAIL rm_after got %0d want 1", bus.contagem);
      nerr++;
    end
  endtask

  initial begin
    nvec         = 0;
    nerr         = 0;
    rst_n        = 1'b0;
    bus.entrada  = '0;
    bus.confirma = 1'b0;
    bus.limpa    = 1'b0;
    test_reset();
    test_media_7();
    test_pronto_nova();
    test_bordas();
    test_erro();
    test_held();
    test_limpa_divide();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/media_notas.md
Name: media_notas

Overview:
- Upstream feeder of the board's grade-letter stage: collects NPROVAS exam scores entered on the switches and confirmed by a push button.
- Computes their floor average by sequential repeated subtraction.
- Presents the average as nota with a valid flag; the downstream stage maps nota to A/F/P on the seven-segment display.

Parameters:
- NBITS_NOTA, 4, width of one score and of the averaged result.
- NOTA_MAX, 10, highest legal score; larger inputs are rejected.
- NPROVAS, 4, number of scores per average; must be ≥2.
- NBITS_SOMA, NBITS_NOTA+$clog2(NPROVAS), accumulator width (6 at defaults; holds NPROVAS*NOTA_MAX).

Ports:
- clk_2  input  1  board clock (divided reference clock).
- rst_n  input  1  reset; synchronous, active-low.
- entrada  input  NBITS_NOTA  score value from SWI.
- confirma  input  1  button level (already synchronous to clk_2); a rising edge submits entrada.
- limpa  input  1  synchronous clear of the current round.
- nota  output  NBITS_NOTA  last computed average.
- nota_valida  output  1  nota holds a completed average.
- contagem  output  $clog2(NPROVAS)+1  scores accepted in the current round.
- ocupado  output  1  division in progress.
- erro  output  1  last submitted score exceeded NOTA_MAX.

Behaviour:
- One clock domain: clk_2. Reset is synchronous and active-low: rst_n low at a rising edge of clk_2 resets everything.
- Reset values: nota=0, nota_valida=0, contagem=0, ocupado=0, erro=0, soma=0, resto=0, quoc=0, confirma_ant=0, state COLETA.
- Edge detect:
  - aceita = confirma & ~confirma_ant.
  - confirma_ant updates every cycle, in every state.
  - A held button yields exactly one submission.
- Priority: rst_n > limpa > aceita.
- limpa:
  - Forces state COLETA; zeroes soma, contagem, erro, nota_valida, ocupado.
  - nota keeps its value.
  - Valid mid-division: the division is abandoned.
- COLETA, on aceita:
  - If entrada > NOTA_MAX: erro=1; soma and contagem unchanged.
  - Otherwise: soma += entrada, contagem += 1, erro=0.
  - If this is score number NPROVAS: next state DIVIDE, resto <= soma+entrada, quoc <= 0, ocupado=1.
- DIVIDE, one step per cycle:
  - If resto ≥ NPROVAS: resto -= NPROVAS, quoc += 1.
  - Otherwise: nota <= quoc, nota_valida <= 1, ocupado <= 0, soma <= 0, contagem <= 0, next state PRONTO.
  - aceita is ignored.
  - Result is the floor of the mean. Latency from the accepting edge to nota_valida=1 is quoc+2 cycles (max NOTA_MAX+2).
- PRONTO:
  - nota and nota_valida are held.
  - On aceita with a legal score: nota_valida <= 0, soma <= entrada, contagem <= 1, next state COLETA.
  - On aceita with an illegal score: erro=1, nota_valida stays 1, state stays PRONTO.
- Widths:
  - soma never overflows because only legal scores are accumulated.
  - quoc is NBITS_NOTA wide and never exceeds NOTA_MAX.
  - Comparisons are unsigned.

Decomposition:
- Package loac_pkg:
  - NBITS_NOTA and NOTA_MAX constants.
  - typedef enum logic [1:0] {COLETA, DIVIDE, PRONTO} estado_media_t.
- Sub-module detector_borda (1-bit rising-edge detector; synchronous active-low reset to 0), instantiated once for confirma.
- Everything else lives in one always_ff block plus next-state logic.

Test Plan:
- Submit 7,8,9,6 (one press each) → contagem reaches 4, ocupado=1 for 8 cycles, then nota=7 (30/4 floor), nota_valida=1; downstream shows A.
- Submit 5,4,3,4 → nota=4, nota_valida=1; a further press with entrada=2 → nota_valida=0, contagem=1.
- Submit 0,0,0,0 → nota=0 valid 2 cycles after the 4th edge. Submit 10,10,10,10 → nota=10 after 12 cycles.
- Submit 3, then 12 → erro=1, contagem stays 1. Then 6 → erro=0, contagem=2.
- Hold confirma high for 20 cycles with entrada=5 → exactly one acceptance (contagem=1).
- Assert limpa during DIVIDE → next cycle state COLETA, ocupado=0, contagem=0, nota_valida=0, nota keeps its old value. Assert rst_n=0 mid-COLETA → all outputs 0 at the next edge.
